// File: rtl/imsic_msi_queue.sv
// MSI request queue in front of an AXI-lite write master: validates and buffers MSIs, then issues
// one IMSIC seteipnum write at a time, in arrival order.
module imsic_msi_queue #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned NR_SRC         = 30,
  parameter int unsigned NR_INTP_FILES  = 2,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter logic [63:0] IMSIC_BASE     = 64'h2400_0000,
  parameter int unsigned NR_SRC_LEN     = $clog2(NR_SRC),
  parameter int unsigned FILE_LEN       = (NR_INTP_FILES > 1) ? $clog2(NR_INTP_FILES) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_msi_valid,
  output logic                      o_msi_ready,
  input  logic [FILE_LEN-1:0]       i_msi_file,
  input  logic [NR_SRC_LEN-1:0]     i_msi_eiid,
  output logic                      o_wr_start,
  output logic [AXI_ADDR_WIDTH-1:0] o_wr_addr,
  output logic [AXI_DATA_WIDTH-1:0] o_wr_data,
  input  logic                      i_wr_busy,
  output logic [$clog2(DEPTH):0]    o_pending,
  output logic [7:0]                o_drop_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StWaitAck, StWaitDone} state_e;

  state_e state_q, state_d;

  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]         count_q;
  logic [7:0]            drop_cnt_q;
  logic [FILE_LEN-1:0]   file_mem [DEPTH];
  logic [NR_SRC_LEN-1:0] eiid_mem [DEPTH];

  logic full, empty, accept, legal, push, pop;
  logic [FILE_LEN-1:0]   head_file;
  logic [NR_SRC_LEN-1:0] head_eiid;

  assign full        = (count_q == (PtrW + 1)'(DEPTH));
  assign empty       = (count_q == '0);
  assign o_msi_ready = !full && !i_rst;
  assign accept      = i_msi_valid && o_msi_ready;
  assign legal       = (i_msi_eiid != '0) && (32'(i_msi_eiid) < NR_SRC) &&
                       (32'(i_msi_file) < NR_INTP_FILES);
  assign push        = accept && legal;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
      // Illegal requests are still accepted (handshake completes) but only counted.
      if (accept && !legal && (drop_cnt_q != 8'hff)) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      file_mem[wr_ptr_q] <= i_msi_file;
      eiid_mem[wr_ptr_q] <= i_msi_eiid;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (!empty && !i_wr_busy) state_d = StStart;
      StStart:    state_d = StWaitAck;
      StWaitAck:  if (i_wr_busy) state_d = StWaitDone;
      StWaitDone: if (!i_wr_busy) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    o_wr_start = (state_q == StStart);
    pop        = (state_q == StWaitDone) && !i_wr_busy;
  end

  assign head_file = file_mem[rd_ptr_q];
  assign head_eiid = eiid_mem[rd_ptr_q];

  always_comb begin
    o_wr_addr = '0;
    o_wr_data = '0;
    if (!empty) begin
      // Each interrupt file is one 4 KiB page above the base.
      o_wr_addr = AXI_ADDR_WIDTH'(IMSIC_BASE) + (AXI_ADDR_WIDTH'(head_file) << 12);
      o_wr_data = AXI_DATA_WIDTH'(head_eiid);
    end
  end

  assign o_pending  = count_q;
  assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_imsic_msi_queue.sv
// Randomized bench for imsic_msi_queue: a queue-based reference model predicts occupancy, head
// address/data, start strobes and drop count every cycle; the bench also plays the write master.
module tb_imsic_msi_queue;

  localparam int DEPTH    = 4;
  localparam int NR_SRC   = 30;
  localparam int NR_FILES = 3;  // three files so that a 2-bit index can name an absent file
  localparam logic [63:0] BASE = 64'h2400_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        msi_valid = 1'b0;
  logic        msi_ready;
  logic [1:0]  msi_file = '0;
  logic [4:0]  msi_eiid = '0;
  logic        wr_start;
  logic [63:0] wr_addr, wr_data;
  logic        wr_busy = 1'b0;
  logic [2:0]  pending;
  logic [7:0]  drop_cnt;

  always #5 clk = ~clk;

  imsic_msi_queue #(
    .DEPTH         (DEPTH),
    .NR_SRC        (NR_SRC),
    .NR_INTP_FILES (NR_FILES),
    .AXI_ADDR_WIDTH(64),
    .AXI_DATA_WIDTH(64),
    .IMSIC_BASE    (BASE)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_msi_valid(msi_valid),
    .o_msi_ready(msi_ready),
    .i_msi_file (msi_file),
    .i_msi_eiid (msi_eiid),
    .o_wr_start (wr_start),
    .o_wr_addr  (wr_addr),
    .o_wr_data  (wr_data),
    .i_wr_busy  (wr_busy),
    .o_pending  (pending),
    .o_drop_cnt (drop_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue of pending writes plus transaction-progress flags.
  logic [63:0] q_addr[$];
  logic [63:0] q_data[$];
  int m_drop  = 0;
  bit m_start = 0;  // a start strobe is due this cycle
  bit m_out   = 0;  // a write is in flight (from its start until busy falls after rising)
  bit m_acked = 0;  // the in-flight write has seen busy high

  // Write-master behaviour.
  bit auto_busy = 0;
  bit man_busy  = 0;
  bit busy_next = 0;
  int m_wait    = 0;
  int m_hold    = 0;

  // Values seen in the most recent cycle.
  logic        obs_start, obs_ready;
  logic [63:0] obs_addr, obs_data;
  logic [2:0]  obs_pending;
  logic [7:0]  obs_drop;
  int          n_starts = 0;

  task automatic run_cycle(input bit v, input logic [1:0] f, input logic [4:0] e, input bit r);
    bit acc, lgl, pop, nstart, nacked, nout;
    int sz;
    logic [63:0] exp_a, exp_d;
    rst       = r;
    msi_valid = v;
    msi_file  = f;
    msi_eiid  = e;
    wr_busy   = auto_busy ? busy_next : man_busy;
    @(negedge clk);
    obs_start   = wr_start;
    obs_ready   = msi_ready;
    obs_addr    = wr_addr;
    obs_data    = wr_data;
    obs_pending = pending;
    obs_drop    = drop_cnt;
    if (wr_start) n_starts++;
    sz    = q_addr.size();
    exp_a = '0;
    exp_d = '0;
    if (sz > 0) begin
      exp_a = q_addr[0];
      exp_d = q_data[0];
    end
    if (r) begin
      check_eq("ready_in_reset", 64'(msi_ready), 64'(0));
    end else begin
      check_eq("pending", 64'(pending), 64'(sz));
      check_eq("ready", 64'(msi_ready), 64'(sz < DEPTH));
      check_eq("start", 64'(wr_start), 64'(m_start));
      check_eq("addr", wr_addr, exp_a);
      check_eq("data", wr_data, exp_d);
      check_eq("drop", 64'(drop_cnt), 64'(m_drop));
    end
    if (r) begin
      q_addr.delete();
      q_data.delete();
      m_drop  = 0;
      m_start = 0;
      m_out   = 0;
      m_acked = 0;
    end else begin
      acc    = v && (sz < DEPTH);
      lgl    = (e != 0) && (int'(e) < NR_SRC) && (int'(f) < NR_FILES);
      pop    = m_acked && !wr_busy;
      nstart = !m_out && (sz > 0) && !wr_busy;
      nacked = m_out && !m_start && !pop && (m_acked || wr_busy);
      nout   = nstart || (m_out && !pop);
      if (pop) begin
        void'(q_addr.pop_front());
        void'(q_data.pop_front());
      end
      if (acc && lgl) begin
        q_addr.push_back(BASE + 64'(f) * 64'h1000);
        q_data.push_back(64'(e));
      end
      if (acc && !lgl && m_drop < 255) m_drop++;
      m_start = nstart;
      m_acked = nacked;
      m_out   = nout;
    end
    // Master: after each start, stay low a little, then busy for a few cycles, then release.
    if (r) begin
      m_wait    = 0;
      m_hold    = 0;
      busy_next = 0;
    end else if (m_start) begin
      m_wait    = $urandom_range(0, 2);
      m_hold    = $urandom_range(1, 4);
      busy_next = 0;
    end else if (m_wait > 0) begin
      m_wait--;
      busy_next = 0;
    end else if (m_hold > 0) begin
      m_hold--;
      busy_next = 1;
    end else if (m_out) begin
      busy_next = !m_acked;
    end else begin
      busy_next = ($urandom_range(0, 9) == 0);
    end
    @(posedge clk);
    #1;
  endtask

  int base_starts;

  initial begin
    run_cycle(0, 0, 0, 1);
    run_cycle(0, 0, 0, 1);
    run_cycle(0, 0, 0, 0);
    check_eq("post_reset_ready", 64'(obs_ready), 64'(1));
    check_eq("post_reset_pending", 64'(obs_pending), 64'(0));

    // Single push, busy during cycles 3..6.
    for (int k = 0; k <= 8; k++) begin
      man_busy = (k >= 3 && k <= 6);
      run_cycle(k == 0, 2'd1, 5'd5, 0);
      if (k == 2) begin
        check_eq("single_start_c2", 64'(obs_start), 64'(1));
        check_eq("single_addr", obs_addr, 64'h2400_1000);
        check_eq("single_data", obs_data, 64'd5);
      end
      if (k == 7) check_eq("single_pending_at_pop", 64'(obs_pending), 64'(1));
      if (k == 8) check_eq("single_pending_after", 64'(obs_pending), 64'(0));
    end

    // Busy already high while an entry waits.
    man_busy = 1;
    for (int k = 0; k <= 6; k++) begin
      if (k == 5) man_busy = 0;
      run_cycle(k == 0, 2'd2, 5'd7, 0);
      if (k >= 1 && k <= 5) check_eq("busy_hold_no_start", 64'(obs_start), 64'(0));
      if (k == 6) check_eq("start_after_busy_falls", 64'(obs_start), 64'(1));
    end
    auto_busy = 1;
    for (int k = 0; k < 12; k++) run_cycle(0, 0, 0, 0);

    // Overfill with a stalled master, then drain in order.
    auto_busy = 0;
    man_busy  = 1;
    for (int i = 0; i < 5; i++) run_cycle(1, 2'(i % 3), 5'(i + 1), 0);
    check_eq("full_ready_low", 64'(obs_ready), 64'(0));
    check_eq("full_pending", 64'(obs_pending), 64'(4));
    base_starts = n_starts;
    auto_busy = 1;
    for (int k = 0; k < 40; k++) run_cycle(0, 0, 0, 0);
    check_eq("drain_start_count", 64'(n_starts - base_starts), 64'(4));

    // Illegal requests are dropped and counted, saturating.
    base_starts = n_starts;
    run_cycle(1, 2'd0, 5'd0, 0);
    run_cycle(1, 2'd1, 5'd30, 0);
    run_cycle(1, 2'd3, 5'd5, 0);
    for (int k = 0; k < 5; k++) run_cycle(0, 0, 0, 0);
    check_eq("drop_three", 64'(obs_drop), 64'(3));
    check_eq("drop_no_writes", 64'(n_starts - base_starts), 64'(0));
    for (int k = 0; k < 300; k++) run_cycle(1, 2'($urandom_range(0, 3)), 5'd0, 0);
    run_cycle(0, 0, 0, 0);
    check_eq("drop_saturated", 64'(obs_drop), 64'(255));

    // Reset while waiting for completion with three entries queued.
    auto_busy = 0;
    man_busy  = 0;
    for (int k = 0; k <= 6; k++) begin
      man_busy = (k >= 3);
      run_cycle(k <= 2, 2'd0, 5'(10 + k), k == 5);
      if (k == 4) check_eq("pre_reset_pending", 64'(obs_pending), 64'(3));
      if (k == 6) begin
        check_eq("flush_pending", 64'(obs_pending), 64'(0));
        check_eq("flush_no_start", 64'(obs_start), 64'(0));
        check_eq("flush_ready", 64'(obs_ready), 64'(1));
      end
    end
    man_busy    = 0;
    base_starts = n_starts;
    for (int k = 0; k < 6; k++) run_cycle(0, 0, 0, 0);
    check_eq("flush_no_retry", 64'(n_starts - base_starts), 64'(0));

    // Randomized traffic with an autonomous master and occasional resets.
    auto_busy = 1;
    for (int k = 0; k < 3000; k++) begin
      bit          v, r;
      logic [1:0]  f;
      logic [4:0]  e;
      v = ($urandom_range(0, 9) < 6);
      f = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      e = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 29));
      r = ($urandom_range(0, 299) == 0);
      run_cycle(v, f, e, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imsic_msi_queue.md
IMSIC_MSI_QUEUE -- requirements
Module: imsic_msi_queue

Interface
REQ-001 Parameter DEPTH, default 4: FIFO entries, power of two, at least 2.
REQ-002 Parameter NR_SRC, default 30: interrupt identities per file; valid EIID range is 1..NR_SRC-1.
REQ-003 Parameter NR_INTP_FILES, default 2: number of target interrupt files.
REQ-004 Parameter AXI_ADDR_WIDTH, default 64; parameter AXI_DATA_WIDTH, default 64.
REQ-005 Parameter IMSIC_BASE, default 64'h2400_0000: base of interrupt file 0; each file occupies one 4 KiB page.
REQ-006 Derived parameters: NR_SRC_LEN = $clog2(NR_SRC); FILE_LEN = $clog2(NR_INTP_FILES), minimum 1.
REQ-007 i_clk  in  1  single clock; all logic is rising-edge.
REQ-008 i_rst  in  1  synchronous, active-high reset.
REQ-009 i_msi_valid  in  1  MSI request valid.
REQ-010 o_msi_ready  out  1  request accepted when high together with i_msi_valid.
REQ-011 i_msi_file  in  FILE_LEN  target interrupt file index.
REQ-012 i_msi_eiid  in  NR_SRC_LEN  external interrupt identity.
REQ-013 o_wr_start  out  1  one-cycle start strobe to the AXI-lite write master.
REQ-014 o_wr_addr  out  AXI_ADDR_WIDTH  write address, held stable from o_wr_start until the transaction completes.
REQ-015 o_wr_data  out  AXI_DATA_WIDTH  write data, held stable over the same window.
REQ-016 i_wr_busy  in  1  write master busy; rises one or more cycles after the start strobe and falls after the B response.
REQ-017 o_pending  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-018 o_drop_cnt  out  8  saturating count of rejected-invalid requests.

Function
REQ-019 o_msi_ready SHALL equal !full; a push SHALL be refused when full even if a pop occurs in the same cycle.
REQ-020 An accepted request with EIID 0, EIID greater than NR_SRC-1, or file index of NR_INTP_FILES or more SHALL be discarded and not enqueued; o_drop_cnt SHALL increment, saturating at 255.
REQ-021 A valid accepted request SHALL be enqueued with address = IMSIC_BASE + (file << 12) and data = EIID zero-extended to AXI_DATA_WIDTH.
REQ-022 The FSM SHALL have four states: IDLE, START, WAIT_ACK and WAIT_DONE.
REQ-023 IDLE -> START SHALL occur when the FIFO is non-empty and i_wr_busy=0; otherwise the FSM SHALL stay in IDLE.
REQ-024 In START, o_wr_start SHALL be 1 for exactly one cycle; the FSM then moves to WAIT_ACK.
REQ-025 WAIT_ACK -> WAIT_DONE SHALL occur when i_wr_busy=1.
REQ-026 WAIT_DONE -> IDLE SHALL occur when i_wr_busy=0; the FIFO head SHALL be popped in that same cycle.
REQ-027 o_wr_addr and o_wr_data SHALL show the FIFO head at all times and SHALL be 0 when the FIFO is empty.
REQ-028 Latency: a push into an empty FIFO with an idle master in cycle N SHALL give o_wr_start=1 in cycle N+2.
REQ-029 Only one write SHALL be outstanding; entries SHALL be issued in strict FIFO order.
REQ-030 Read and write pointers SHALL wrap modulo DEPTH; o_pending SHALL stay exact across wrap, including push and pop in the same cycle.
REQ-031 A push in the pop cycle while not full SHALL change o_pending by net 0.

Reset
REQ-032 While i_rst=1 at a clock edge: FSM = IDLE, pointers and o_pending = 0, o_drop_cnt = 0, o_wr_start = 0, o_wr_addr = 0, o_wr_data = 0.
REQ-033 o_msi_ready SHALL be 0 during reset and 1 in the first cycle after reset release.
REQ-034 Reset in any state, including WAIT_ACK and WAIT_DONE, SHALL flush the FIFO; no retry or completion SHALL follow after release.

Verification
REQ-035 Single push file=1, EIID=5, master busy for cycles 3..6 -> o_wr_start in cycle 2, addr=0x2400_1000, data=5; pop in cycle 7; o_pending returns to 0.
REQ-036 Five back-to-back pushes with DEPTH=4 and a stalled master -> o_msi_ready low after the fourth push, o_pending=4; after drain, writes issue in push order.
REQ-037 Pushes with EIID=0, EIID=30 and file=2 -> no writes issued, o_drop_cnt=3; after 300 invalid pushes, o_drop_cnt=255.
REQ-038 i_wr_busy already high while the FIFO is non-empty -> no o_wr_start until busy falls, then start the following cycle.
REQ-039 Assert i_rst in WAIT_DONE with 3 entries pending -> next cycle o_pending=0, o_wr_start stays 0, o_msi_ready=1.
REQ-040 Sustained push/pop across 10 entries with DEPTH=4 -> o_pending exact at every wrap, correct address/data order throughout.
